// File: rtl/text_console_writer.sv
// text_console_writer: cursor-tracked character writer for the VGA text-cell RAM.
// Clears the screen after reset, then accepts one character per handshake, decodes
// CR/LF/BS/FF, and optionally blanks each newly entered row.
module text_console_writer #(
  parameter int unsigned COLS       = 64,
  parameter int unsigned ROWS       = 19,
  parameter int unsigned ADDR_W     = 16,
  parameter logic [7:0]  CLEAR_CHAR = 8'h00,
  parameter logic [7:0]  DEF_ATTR   = 8'h0F,
  parameter bit          ROW_CLEAR  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_char,
  input  logic [7:0]               in_attr,
  input  logic                     in_use_attr,
  input  logic                     clear_req,
  output logic                     busy,
  output logic                     wen,
  output logic [ADDR_W-1:0]        waddr,
  output logic [7:0]               wdataText,
  output logic [7:0]               wdataAttr,
  output logic [$clog2(COLS)-1:0]  cursor_col,
  output logic [$clog2(ROWS)-1:0]  cursor_row
);

  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned CNT_W = $clog2(CELLS);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    S_CLEAR   = 2'd0,
    S_IDLE    = 2'd1,
    S_LINECLR = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [7:0]         cur_attr;

  logic [ADDR_W-1:0]  row_base;
  logic [ADDR_W-1:0]  cell_addr;
  logic [ROW_W-1:0]   next_row;
  logic               col_at_end;
  logic [7:0]         eff_attr;

  // Cursor-derived addresses and helpers shared by the write paths
  always_comb begin
    row_base   = ADDR_W'(cursor_row) * ADDR_W'(COLS);
    cell_addr  = row_base + ADDR_W'(cursor_col);
    next_row   = (cursor_row == ROW_W'(ROWS - 1)) ? '0 : cursor_row + ROW_W'(1);
    col_at_end = (cursor_col == COL_W'(COLS - 1));
    eff_attr   = in_use_attr ? in_attr : cur_attr;
    in_ready   = (state == S_IDLE) && !clear_req;
    busy       = (state != S_IDLE);
  end

  // Writer FSM: full clear, character decode and row clear, with registered RAM port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_CLEAR;
      cnt        <= '0;
      cur_attr   <= DEF_ATTR;
      cursor_col <= '0;
      cursor_row <= '0;
      wen        <= 1'b0;
      waddr      <= '0;
      wdataText  <= 8'h00;
      wdataAttr  <= 8'h00;
    end else begin
      wen <= 1'b0;
      case (state)
        S_CLEAR: begin
          if (clear_req) begin
            cnt <= '0;
          end else begin
            wen       <= 1'b1;
            waddr     <= ADDR_W'(cnt);
            wdataText <= CLEAR_CHAR;
            wdataAttr <= DEF_ATTR;
            if (cnt == CNT_W'(CELLS - 1)) begin
              cnt        <= '0;
              cursor_col <= '0;
              cursor_row <= '0;
              state      <= S_IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        S_IDLE: begin
          if (clear_req) begin
            cnt   <= '0;
            state <= S_CLEAR;
          end else if (in_valid) begin
            if (in_use_attr) cur_attr <= in_attr;
            case (in_char)
              CH_CR: begin
                cursor_col <= '0;
              end
              CH_LF: begin
                cursor_col <= '0;
                cursor_row <= next_row;
                if (ROW_CLEAR) begin
                  cnt   <= '0;
                  state <= S_LINECLR;
                end
              end
              CH_BS: begin
                if (cursor_col != '0) begin
                  cursor_col <= cursor_col - COL_W'(1);
                  wen        <= 1'b1;
                  waddr      <= cell_addr - ADDR_W'(1);
                  wdataText  <= CLEAR_CHAR;
                  wdataAttr  <= eff_attr;
                end
              end
              CH_FF: begin
                cnt   <= '0;
                state <= S_CLEAR;
              end
              default: begin
                wen       <= 1'b1;
                waddr     <= cell_addr;
                wdataText <= in_char;
                wdataAttr <= eff_attr;
                if (col_at_end) begin
                  cursor_col <= '0;
                  cursor_row <= next_row;
                  if (ROW_CLEAR) begin
                    cnt   <= '0;
                    state <= S_LINECLR;
                  end
                end else begin
                  cursor_col <= cursor_col + COL_W'(1);
                end
              end
            endcase
          end
        end

        S_LINECLR: begin
          if (clear_req) begin
            cnt   <= '0;
            state <= S_CLEAR;
          end else begin
            wen       <= 1'b1;
            waddr     <= row_base + ADDR_W'(cnt);
            wdataText <= CLEAR_CHAR;
            wdataAttr <= DEF_ATTR;
            if (cnt == CNT_W'(COLS - 1)) begin
              cnt   <= '0;
              state <= S_IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          cnt   <= '0;
          state <= S_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer: expected RAM writes are queued ahead of
// stimulus and a monitor pops and compares every wen cycle.
module tb_text_console_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_char;
  logic [7:0]  in_attr;
  logic        in_use_attr;
  logic        clear_req;
  logic        busy;
  logic        wen;
  logic [15:0] waddr;
  logic [7:0]  wdataText;
  logic [7:0]  wdataAttr;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  text;
    logic [7:0]  attr;
  } wr_t;

  wr_t exp_q[$];
  int  vectors = 0;
  int  errors  = 0;

  text_console_writer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .in_attr    (in_attr),
    .in_use_attr(in_use_attr),
    .clear_req  (clear_req),
    .busy       (busy),
    .wen        (wen),
    .waddr      (waddr),
    .wdataText  (wdataText),
    .wdataAttr  (wdataAttr),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic push(input int addr, input int text, input int attr);
    wr_t e;
    e.addr = 16'(addr);
    e.text = 8'(text);
    e.attr = 8'(attr);
    exp_q.push_back(e);
  endtask

  task automatic push_clear();
    for (int i = 0; i < 1216; i++) push(i, 8'h00, 8'h0F);
  endtask

  task automatic push_row(input int row);
    for (int i = 0; i < 64; i++) push(row * 64 + i, 8'h00, 8'h0F);
  endtask

  // Present one character and hold it until accepted, then drop in_valid
  task automatic send(input logic [7:0] ch, input logic use_attr, input logic [7:0] attr);
    int n;
    @(negedge clk);
    in_char     = ch;
    in_use_attr = use_attr;
    in_attr     = attr;
    in_valid    = 1'b1;
    n = 0;
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout: char 0x%0h never accepted", ch);
    end
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_use_attr = 1'b0;
  endtask

  // Wait for every expected write to appear, then allow idle cycles to expose extra writes
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_char     = 8'h00;
    in_attr     = 8'h00;
    in_use_attr = 1'b0;
    clear_req   = 1'b0;

    // Write monitor: every wen cycle must match the head of the expected queue
    fork
      forever begin
        @(negedge clk);
        if (wen === 1'b1) begin
          vectors++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr %0d text 0x%0h attr 0x%0h", waddr, wdataText, wdataAttr);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            if ({waddr, wdataText, wdataAttr} !== {e.addr, e.text, e.attr}) begin
              errors++;
              $display("FAIL write: got addr %0d text 0x%0h attr 0x%0h expected addr %0d text 0x%0h attr 0x%0h",
                       waddr, wdataText, wdataAttr, e.addr, e.text, e.attr);
            end
          end
        end
      end
    join_none

    // Reset values
    #3 rst = 1'b0;
    #4;
    check("rst_wen", int'(wen), 0);
    check("rst_waddr", int'(waddr), 0);
    check("rst_text", int'(wdataText), 0);
    check("rst_attr", int'(wdataAttr), 0);
    check("rst_col", int'(cursor_col), 0);
    check("rst_row", int'(cursor_row), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_ready", int'(in_ready), 0);

    // Power-up clear
    push_clear();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    begin
      int n;
      n = 0;
      while (!in_ready && n < 3000) begin
        @(negedge clk);
        n++;
      end
    end
    check("clear_done_ready", int'(in_ready), 1);
    check("clear_done_busy", int'(busy), 0);
    drain("drain_powerup");

    // 'A' with attribute load, then 'B' inheriting it; write latency of one cycle
    push(0, 8'h41, 8'h1E);
    push(1, 8'h42, 8'h1E);
    send(8'h41, 1'b1, 8'h1E);
    @(negedge clk);
    check("latency_wen", int'(wen), 1);
    send(8'h42, 1'b0, 8'h55);
    drain("drain_ab");
    check("ab_col", int'(cursor_col), 2);
    check("ab_row", int'(cursor_row), 0);

    // CR then a full row of printable chars: wrap, row advance and row clear
    send(8'h0D, 1'b0, 8'h00);
    for (int i = 0; i < 64; i++) push(i, 8'h20 + i, 8'h1E);
    push_row(1);
    for (int i = 0; i < 64; i++) send(8'(8'h20 + i), 1'b0, 8'h00);
    @(negedge clk);
    check("lineclr_busy", int'(busy), 1);
    check("lineclr_ready", int'(in_ready), 0);
    drain("drain_wrap");
    check("wrap_col", int'(cursor_col), 0);
    check("wrap_row", int'(cursor_row), 1);

    // Walk down to row 18 col 5, then LF wraps to row 0 and clears it
    for (int r = 2; r <= 18; r++) push_row(r);
    for (int r = 2; r <= 18; r++) send(8'h0A, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) push(1152 + i, 8'h61 + i, 8'h1E);
    for (int i = 0; i < 5; i++) send(8'(8'h61 + i), 1'b0, 8'h00);
    drain("drain_row18");
    check("r18_col", int'(cursor_col), 5);
    check("r18_row", int'(cursor_row), 18);
    push_row(0);
    send(8'h0A, 1'b0, 8'h00);
    drain("drain_lf_wrap");
    check("lfwrap_col", int'(cursor_col), 0);
    check("lfwrap_row", int'(cursor_row), 0);

    // Row 2, attribute loaded on a CR, three chars then BS; BS at col 0 is a no-op
    push_row(1);
    push_row(2);
    send(8'h0A, 1'b0, 8'h00);
    send(8'h0A, 1'b0, 8'h00);
    send(8'h0D, 1'b1, 8'h70);
    push(128, 8'h78, 8'h70);
    push(129, 8'h79, 8'h70);
    push(130, 8'h7A, 8'h70);
    send(8'h78, 1'b0, 8'h00);
    send(8'h79, 1'b0, 8'h00);
    send(8'h7A, 1'b0, 8'h00);
    drain("drain_xyz");
    check("bs_pre_col", int'(cursor_col), 3);
    check("bs_pre_row", int'(cursor_row), 2);
    push(130, 8'h00, 8'h70);
    send(8'h08, 1'b0, 8'h00);
    drain("drain_bs");
    check("bs_col", int'(cursor_col), 2);
    send(8'h0D, 1'b0, 8'h00);
    send(8'h08, 1'b0, 8'h00);
    drain("drain_bs0");
    check("bs0_col", int'(cursor_col), 0);
    check("bs0_row", int'(cursor_row), 2);

    // FF clears the screen, resets the cursor and keeps the current attribute
    push_clear();
    send(8'h0C, 1'b0, 8'h00);
    drain("drain_ff");
    check("ff_col", int'(cursor_col), 0);
    check("ff_row", int'(cursor_row), 0);
    check("ff_busy", int'(busy), 0);
    push(0, 8'h4B, 8'h70);
    send(8'h4B, 1'b0, 8'h00);
    drain("drain_k");
    check("k_col", int'(cursor_col), 1);

    // clear_req with a char pending in IDLE: not accepted, full clear follows
    push_clear();
    @(negedge clk);
    clear_req = 1'b1;
    in_valid  = 1'b1;
    in_char   = 8'h51;
    #1;
    check("clrreq_ready", int'(in_ready), 0);
    @(negedge clk);
    clear_req = 1'b0;
    in_valid  = 1'b0;
    check("clrreq_busy", int'(busy), 1);
    drain("drain_clrreq");
    check("clrreq_col", int'(cursor_col), 0);
    check("clrreq_row", int'(cursor_row), 0);

    // clear_req after four row-clear writes aborts the row clear and restarts at 0
    for (int i = 0; i < 4; i++) push(64 + i, 8'h00, 8'h0F);
    push_clear();
    send(8'h0A, 1'b0, 8'h00);
    repeat (5) @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    check("abort_busy", int'(busy), 1);
    drain("drain_abort");
    check("abort_col", int'(cursor_col), 0);
    check("abort_row", int'(cursor_row), 0);
    check("abort_ready", int'(in_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
